// File: rtl/ps2_rx_filter.sv
// PS/2 device-to-host receiver with line conditioning, frame validation and a
// make-code filter that drops break sequences (F0 xx) and E0 prefixes.
module ps2_rx_filter #(
  parameter int N          = 8,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ps2c,
  input  logic         ps2d,
  input  logic         rx_en,
  output logic [N-1:0] data_out,
  output logic         rx_done_tick,
  output logic         frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(N + 2);
  localparam int SW = N + 2;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  // Index 0 carries the clock line, index 1 the data line.
  logic [1:0]    c_sync, d_sync;
  logic [1:0]    raw, filt;
  logic [FW-1:0] fcnt [2];
  logic          c_prev;
  logic          fall_tick;

  // NOTE: sequential state is always updated with <= so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync <= '1;
      d_sync <= '1;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
    end
  end

  assign raw = {d_sync[1], c_sync[1]};

  // A line level is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt    <= '1;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
      c_prev  <= 1'b1;
    end else begin
      c_prev <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall_tick = c_prev & ~filt[0];

  state_t        state, state_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [SW-1:0] sreg, sreg_n;
  logic [WW-1:0] wd, wd_n;
  logic          brk, brk_n;
  logic [N-1:0]  dout_n;
  logic          done_n, err_n;
  logic          frame_ok;
  logic [N-1:0]  code;

  // Frame is LSB first, so after the stop bit sreg = {stop, parity, data}.
  assign code     = sreg[N-1:0];
  assign frame_ok = (^sreg[N:0]) & sreg[N+1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      sreg         <= '0;
      wd           <= '0;
      brk          <= 1'b0;
      data_out     <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_n;
      sreg         <= sreg_n;
      wd           <= wd_n;
      brk          <= brk_n;
      data_out     <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= err_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    sreg_n  = sreg;
    wd_n    = wd;
    brk_n   = brk;
    dout_n  = '0;
    done_n  = 1'b0;
    err_n   = 1'b0;

    unique case (state)
      IDLE: begin
        wd_n = '0;
        if (fall_tick && rx_en && !filt[1]) begin
          state_n = SHIFT;
          bit_n   = '0;
          sreg_n  = '0;
        end
      end

      SHIFT: begin
        if (fall_tick) begin
          sreg_n = {filt[1], sreg[SW-1:1]};
          wd_n   = '0;
          bit_n  = bit_cnt + 1'b1;
          if (bit_cnt == BW'(N + 1)) state_n = CHECK;
        end else if (wd == WW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          sreg_n  = '0;
          state_n = IDLE;
        end else begin
          wd_n = wd + 1'b1;
        end
      end

      CHECK: begin
        state_n = IDLE;
        if (!frame_ok) begin
          err_n = 1'b1;
        end else if (code == N'(8'hF0)) begin
          brk_n = 1'b1;
        end else if (code == N'(8'hE0)) begin
          brk_n = brk;
        end else if (brk) begin
          brk_n = 1'b0;
        end else begin
          dout_n = code;
          done_n = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_rx_filter.sv
// Directed self-checking bench for ps2_rx_filter: frames are bit-banged on the
// PS/2 pins and a monitor tallies strobes, codes and output-protocol violations.
module tb_ps2_rx_filter;

  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int H    = 40;   // PS/2 half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c, ps2d, rx_en;
  logic [7:0] data_out;
  logic       rx_done_tick, frame_err;

  ps2_rx_filter #(.N(8), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .rx_en       (rx_en),
    .data_out    (data_out),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         n_tick = 0, n_err = 0, n_both = 0, n_leak = 0, n_long = 0;
  int         tick_cyc = 0, stop_cyc = 0;
  logic       prev_tick = 1'b0;
  logic [7:0] codes [$];
  logic [7:0] r_dout;
  logic       r_tick, r_err;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_done_tick) begin
        n_tick++;
        tick_cyc = cyc;
        codes.push_back(data_out);
        if (prev_tick) n_long++;
      end else if (data_out !== 8'h00) begin
        n_leak++;
      end
      if (frame_err) n_err++;
      if (rx_done_tick && frame_err) n_both++;
    end
    prev_tick = rx_done_tick;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                           input logic stop);
    return {stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Sends the first nbits of a frame; rst_at >= 0 pulses reset in that bit's low phase.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int rst_at);
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      repeat (H) @(negedge clk);
      ps2c = 1'b0;
      if (i == 10) stop_cyc = cyc;
      if (i == rst_at) begin
        repeat (H / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        r_dout = data_out;
        r_tick = rx_done_tick;
        r_err  = frame_err;
        repeat (H - H / 2 - 1) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    send_bits(mk_frame(b, bad_par, stop), 11, -1);
  endtask

  task automatic expect_one_code(input string name, input int t0, input logic [7:0] exp);
    checks++;
    if (n_tick - t0 !== 1) begin
      errors++;
      $display("FAIL %s strobes: got %0d want 1", name, n_tick - t0);
    end
    checks++;
    if (codes.size() == 0 || codes[codes.size()-1] !== exp) begin
      errors++;
      $display("FAIL %s code: got %h want %h", name,
               (codes.size() == 0) ? 8'hxx : codes[codes.size()-1], exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out, rx_done_tick, frame_err} !== 10'b0) begin
      errors++;
      $display("FAIL reset outputs: got %h/%b/%b want 00/0/0", data_out, rx_done_tick, frame_err);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_make;
    int t0, e0, lat;
    t0 = n_tick; e0 = n_err;
    send_frame(8'h5A, 1'b0, 1'b1);
    expect_one_code("make_5A", t0, 8'h5A);
    lat = tick_cyc - stop_cyc;
    checks++;
    if (lat < FL + 4 || lat > FL + 5) begin
      errors++;
      $display("FAIL make latency: got %0d want %0d..%0d", lat, FL + 4, FL + 5);
    end
    checks++;
    if (n_err - e0 !== 0) begin
      errors++;
      $display("FAIL make frame_err: got %0d want 0", n_err - e0);
    end
  endtask

  task automatic test_break;
    int t0;
    t0 = n_tick;
    send_frame(8'h16, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h16, 1'b0, 1'b1);
    expect_one_code("break_16", t0, 8'h16);
    t0 = n_tick;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h1E, 1'b0, 1'b1);
    expect_one_code("after_break_1E", t0, 8'h1E);
  endtask

  task automatic test_errors;
    int t0, e0;
    t0 = n_tick; e0 = n_err;
    send_frame(8'h26, 1'b1, 1'b1);
    checks++;
    if (n_err - e0 !== 1 || n_tick !== t0) begin
      errors++;
      $display("FAIL parity_err: got err %0d tick %0d want 1/0", n_err - e0, n_tick - t0);
    end
    t0 = n_tick; e0 = n_err;
    send_frame(8'h26, 1'b0, 1'b0);
    checks++;
    if (n_err - e0 !== 1 || n_tick !== t0) begin
      errors++;
      $display("FAIL stop_err: got err %0d tick %0d want 1/0", n_err - e0, n_tick - t0);
    end
  endtask

  task automatic test_timeout;
    int t0, e0;
    t0 = n_tick; e0 = n_err;
    send_bits(mk_frame(8'h25, 1'b0, 1'b1), 5, -1);
    repeat (TO + 10) @(negedge clk);
    checks++;
    if (n_err - e0 !== 1 || n_tick !== t0) begin
      errors++;
      $display("FAIL timeout: got err %0d tick %0d want 1/0", n_err - e0, n_tick - t0);
    end
    send_frame(8'h25, 1'b0, 1'b1);
    expect_one_code("after_timeout_25", t0, 8'h25);
  endtask

  task automatic test_glitch;
    int t0, e0;
    t0 = n_tick; e0 = n_err;
    ps2d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ps2c = 1'b0;
      repeat (3) @(negedge clk);
      ps2c = 1'b1;
      repeat (20) @(negedge clk);
    end
    repeat (TO + 30) @(negedge clk);
    ps2d = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (n_err !== e0 || n_tick !== t0) begin
      errors++;
      $display("FAIL glitch: got err %0d tick %0d want 0/0", n_err - e0, n_tick - t0);
    end
  endtask

  task automatic test_reset_mid;
    int t0, e0;
    send_frame(8'hF0, 1'b0, 1'b1);
    t0 = n_tick; e0 = n_err;
    send_bits(mk_frame(8'hFF, 1'b0, 1'b1), 11, 5);
    checks++;
    if ({r_dout, r_tick, r_err} !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid outputs: got %h/%b/%b want 00/0/0", r_dout, r_tick, r_err);
    end
    checks++;
    if (n_err !== e0 || n_tick !== t0) begin
      errors++;
      $display("FAIL reset_mid residue: got err %0d tick %0d want 0/0", n_err - e0, n_tick - t0);
    end
    send_frame(8'h46, 1'b0, 1'b1);
    expect_one_code("after_reset_46", t0, 8'h46);
  endtask

  task automatic test_rx_en;
    int t0;
    t0 = n_tick;
    rx_en = 1'b0;
    send_frame(8'h3D, 1'b0, 1'b1);
    checks++;
    if (n_tick !== t0) begin
      errors++;
      $display("FAIL rx_en_off: got %0d strobes want 0", n_tick - t0);
    end
    rx_en = 1'b1;
    send_frame(8'h3D, 1'b0, 1'b1);
    expect_one_code("rx_en_on_3D", t0, 8'h3D);
  endtask

  task automatic test_back_to_back;
    int t0;
    t0 = n_tick;
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++;
    if (n_tick - t0 !== 2 || codes[codes.size()-1] !== 8'h1C || codes[codes.size()-2] !== 8'h1C) begin
      errors++;
      $display("FAIL typematic: got %0d strobes want 2 of 1C", n_tick - t0);
    end
  endtask

  task automatic test_protocol;
    checks++;
    if (n_both !== 0 || n_leak !== 0 || n_long !== 0) begin
      errors++;
      $display("FAIL protocol: both %0d leak %0d long %0d want 0/0/0", n_both, n_leak, n_long);
    end
  endtask

  initial begin
    test_reset;
    test_make;
    test_break;
    test_errors;
    test_timeout;
    test_glitch;
    test_reset_mid;
    test_rx_en;
    test_back_to_back;
    test_protocol;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_filter.md
# ps2_rx_filter

PS/2 keyboard receiver and make-code filter. It deserializes PS/2 device-to-host frames and checks them. It drops break sequences (F0 xx) and E0 prefixes, and presents each accepted make code on `data_out` for exactly one clock. Sits directly upstream of the key validation FSM, whose `data_in` it drives. That FSM therefore sees 8'h00 except on the single cycle a key is pressed.

## Interface
- `N`, 8: scan-code width.
- `FILTER_LEN`, 8: consecutive identical samples required before a synchronized PS/2 line level is accepted.
- `TIMEOUT`, 50000: clk cycles allowed between falling edges inside a frame (1 ms at 50 MHz).
- `clk` in 1: system clock; the only clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `ps2c` in 1: PS/2 clock line, asynchronous.
- `ps2d` in 1: PS/2 data line, asynchronous.
- `rx_en` in 1: when low, no new frame is started; a frame in progress completes.
- `data_out` out N: accepted make code during the `rx_done_tick` cycle, 8'h00 otherwise.
- `rx_done_tick` out 1: one-cycle strobe, `data_out` valid.
- `frame_err` out 1: one-cycle strobe on parity, stop-bit or timeout error.

## Operation
**Input conditioning**
- `ps2c` and `ps2d` each pass through a 2-FF synchronizer.
- A filter follows: the filtered level changes only after `FILTER_LEN` consecutive equal samples.
- `fall_tick` = filtered `ps2c` goes 1→0. Filtered `ps2d` is sampled on `fall_tick`.

**Frame format**
- Start bit 0, 8 data bits LSB first, odd parity, stop bit 1.

**FSM states: IDLE, SHIFT, CHECK**
- **IDLE:**
  - On `fall_tick` with `rx_en`=1 and sampled data 0: go to SHIFT, bit counter = 0, watchdog cleared.
  - If sampled start bit is 1: stay in IDLE, no error.
- **SHIFT:**
  - Each `fall_tick` shifts the sampled bit into a 10-bit register (8 data, parity, stop).
  - After the 10th bit: go to CHECK.
  - The watchdog counts clk cycles since the last `fall_tick`. Reaching `TIMEOUT`: `frame_err`=1 for one cycle, go to IDLE, shift register discarded.
- **CHECK (one cycle):** validate, then return to IDLE.
  - Valid means XOR of 8 data bits and parity = 1, and stop bit = 1.
  - Invalid: pulse `frame_err`, no output, break flag unchanged.

**Code filter (valid bytes only)**
- 8'hF0: set break flag, no output.
- 8'hE0: no output, flags unchanged.
- Any byte while break flag set: clear flag, no output.
- Otherwise: `data_out` = byte, `rx_done_tick`=1 for one cycle.
- Typematic repeats of a held key are distinct valid frames and are output each time.

**Reset values**
- State IDLE, counters 0, shift register 0, break flag 0.
- Synchronizers and filters load 1 (idle bus).
- `data_out`=8'h00, `rx_done_tick`=0, `frame_err`=0.

## Timing
- `fall_tick` asserts `2+FILTER_LEN` to `3+FILTER_LEN` cycles after a `ps2c` pin edge.
- The stop-bit `fall_tick` moves the FSM to CHECK on the next edge.
- Outputs are registered and assert the cycle after CHECK, i.e. 2 clk after the stop-bit `fall_tick`.
- Outputs return to 0 one cycle later.
- `rx_done_tick` and `frame_err` are never high together.
- Reset asserted mid-frame: next edge forces IDLE and clears the break flag. The rest of the interrupted frame on the bus is treated as line noise; data-1 bits do not start a frame.
- `reset` dominates all other inputs.
- `rx_en` falling mid-frame has no effect until return to IDLE.

## Test plan
- **Make code:** send frame 8'h5A (parity 1, stop 1) at 12.5 kHz → `data_out`=8'h5A with `rx_done_tick`=1 for exactly 1 cycle, 2 clk after the stop-bit `fall_tick`. `data_out`=8'h00 before and after.
- **Break sequence:** send 8'h16, then 8'hF0, then 8'h16 → exactly one strobe, with 8'h16. Break flag clear afterward; a following 8'h1E is output.
- **Errors:**
  - Frame 8'h26 with parity bit inverted → `frame_err` 1 cycle, no `rx_done_tick`.
  - Frame 8'h26 with stop bit 0 → same response.
- **Timeout:** send start + 4 data bits, then hold `ps2c` high for `TIMEOUT`+10 cycles → `frame_err` 1 cycle. A subsequent complete 8'h25 frame outputs 8'h25.
- **Glitch rejection:** 3-cycle low pulses on `ps2c` (< `FILTER_LEN`) while idle → no `fall_tick`, no outputs.
- **Reset and enable:**
  - Assert `reset` for 1 cycle during bit 5 of a frame → all outputs 0. The next full 8'h46 frame outputs 8'h46.
  - With `rx_en`=0, send 8'h3D → no strobe.
